// File: rtl/move_scheduler.sv
// Game-state sequencer for the maze game: frame-divided move enables for Pacman and
// the ghosts, plus a round-robin arbiter sharing one maze-memory read port.
module move_scheduler #(
  parameter int PAC_DIV   = 2,
  parameter int GHOST_DIV = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        win,
  input  logic        lose,
  input  logic        frame_tick,
  input  logic [2:0]  req,
  input  logic [29:0] req_x,
  input  logic [29:0] req_y,
  input  logic        maze_wall,
  output logic [1:0]  game_state,
  output logic        step_pac,
  output logic        step_ghost,
  output logic        maze_rd,
  output logic [9:0]  maze_x,
  output logic [9:0]  maze_y,
  output logic [2:0]  grant,
  output logic [2:0]  rsp_valid,
  output logic        rsp_wall
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  localparam logic [3:0] PAC_LAST   = 4'(PAC_DIV - 1);
  localparam logic [3:0] GHOST_LAST = 4'(GHOST_DIV - 1);

  state_t      state, next_state;
  logic        in_play, enter_play;
  logic [3:0]  pac_cnt, ghost_cnt;
  logic [1:0]  rr_ptr, sel_idx;
  logic        sel_found;
  logic [2:0]  sel_oh, eligible, busy, pend;
  logic [9:0]  sel_x, sel_y;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Lose wins over win when both arrive in the same PLAY cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = PLAY;
      PLAY:      if (lose) next_state = LOSE;
                 else if (win) next_state = WIN;
      WIN, LOSE: if (ack) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    game_state = state;
  end

  assign in_play    = (state == PLAY);
  assign enter_play = !in_play && (next_state == PLAY);

  // A tick that also leaves PLAY must not produce a step in the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pac_cnt    <= '0;
      ghost_cnt  <= '0;
      step_pac   <= 1'b0;
      step_ghost <= 1'b0;
    end else begin
      step_pac   <= 1'b0;
      step_ghost <= 1'b0;
      if (enter_play) begin
        pac_cnt   <= '0;
        ghost_cnt <= '0;
      end else if (in_play && frame_tick) begin
        if (pac_cnt >= PAC_LAST) begin
          pac_cnt  <= '0;
          step_pac <= (next_state == PLAY);
        end else begin
          pac_cnt <= pac_cnt + 4'd1;
        end
        if (ghost_cnt >= GHOST_LAST) begin
          ghost_cnt  <= '0;
          step_ghost <= (next_state == PLAY);
        end else begin
          ghost_cnt <= ghost_cnt + 4'd1;
        end
      end
    end
  end

  assign eligible = req & ~busy & {3{in_play}};

  // Scan downward so the candidate nearest rr_ptr is the one left selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (eligible[wrap3({1'b0, rr_ptr} + 3'(k))]) begin
        sel_found = 1'b1;
        sel_idx   = wrap3({1'b0, rr_ptr} + 3'(k));
      end
    end
  end

  assign sel_oh = sel_found ? (3'b001 << sel_idx) : 3'b000;

  always_comb begin
    case (sel_idx)
      2'd1:    begin sel_x = req_x[19:10]; sel_y = req_y[19:10]; end
      2'd2:    begin sel_x = req_x[29:20]; sel_y = req_y[29:20]; end
      default: begin sel_x = req_x[9:0];   sel_y = req_y[9:0];   end
    endcase
  end

  // pend marks the cycle the memory is answering; its owner is released on the response edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maze_rd   <= 1'b0;
      grant     <= '0;
      maze_x    <= '0;
      maze_y    <= '0;
      rr_ptr    <= '0;
      busy      <= '0;
      pend      <= '0;
      rsp_valid <= '0;
      rsp_wall  <= 1'b0;
    end else begin
      maze_rd <= sel_found;
      grant   <= sel_oh;
      if (sel_found) begin
        maze_x <= sel_x;
        maze_y <= sel_y;
        rr_ptr <= wrap3({1'b0, sel_idx} + 3'd1);
      end
      busy      <= (busy | sel_oh) & ~pend;
      pend      <= grant;
      rsp_valid <= pend;
      rsp_wall  <= maze_wall & (|pend);
    end
  end

endmodule
